tiny_cpu_sequencer: RTL

Host-side driver for the TinyCPU instruction/result interface. It holds a small program of 12-bit instruction words, presents them one at a time on the CPU's In bus, and captures the CPU's 8-bit Result for each instruction. The CPU consumes In and produces Result; this block produces In and consumes Result. It sits between a host/testbench control port and the CPU core.

---
 rtl/tiny_cpu_pkg.sv | 15 +
 rtl/tiny_cpu_prog_mem.sv | 25 ++
 rtl/tiny_cpu_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared TinyCPU definitions: bus widths, the NOP encoding and the sequencer state type.
package tiny_cpu_pkg;

  localparam int INSTR_W  = 12;
  localparam int RESULT_W = 8;

  localparam logic [INSTR_W-1:0] NOP = 12'h000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } seq_state_e;

endpackage

// File: rtl/tiny_cpu_prog_mem.sv
// Program store: DEPTH x INSTR_W words, synchronous write, asynchronous read, no reset.
module tiny_cpu_prog_mem
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               Clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write port; contents survive reset so a program can be rerun after an abort.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tiny_cpu_sequencer.sv
// Drives a stored program onto the CPU In bus one word at a time and captures each Result.
module tiny_cpu_sequencer
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int RES_LAT = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Prog_we,
  input  logic [AW-1:0]       Prog_addr,
  input  logic [INSTR_W-1:0]  Prog_data,
  input  logic                Start,
  input  logic [AW:0]         Length,
  output logic                Busy,
  output logic                Done,
  output logic [INSTR_W-1:0]  In,
  input  logic [RESULT_W-1:0] Result,
  output logic                Res_valid,
  output logic [RESULT_W-1:0] Res_data,
  output logic [AW-1:0]       Res_index
);

  // Wait counter is at least one bit wide even for a combinational CPU.
  localparam int CW = (RES_LAT < 1) ? 1 : $clog2(RES_LAT + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(RES_LAT);
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);

  seq_state_e         state, state_nx;
  logic [AW-1:0]      pc;
  logic [AW:0]        len;
  logic [CW-1:0]      cnt;
  logic [AW:0]        len_cl;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               load, cap, is_last;

  // Slot 0 is fetched on launch, pc+1 on every advance; pc never passes len-1, so no wrap.
  assign rd_addr = (state == RUN) ? pc + 1'b1 : '0;
  assign len_cl  = (Length > DEPTH_L) ? DEPTH_L : Length;
  assign is_last = ({1'b0, pc} == (len - 1'b1));
  assign Busy    = (state != IDLE);

  tiny_cpu_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .Clk   (Clk),
    .we    (Prog_we && (state == IDLE)),
    .waddr (Prog_addr),
    .wdata (Prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus launch/capture strobes for the datapath.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    cap      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Length == '0) state_nx = FINISH;
          else begin
            state_nx = RUN;
            load     = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == '0) begin
          cap = 1'b1;
          if (is_last) state_nx = FINISH;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: program counter, latency counter, In bus and result capture.
  // Done is registered off FINISH so it lands one cycle after the last Res_valid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc        <= '0;
      len       <= '0;
      cnt       <= '0;
      In        <= NOP;
      Done      <= 1'b0;
      Res_valid <= 1'b0;
      Res_data  <= '0;
      Res_index <= '0;
    end else begin
      Res_valid <= cap;
      Done      <= (state == FINISH);
      if (load) begin
        len <= len_cl;
        pc  <= '0;
        In  <= rd_data;
        cnt <= CNT_RELOAD;
      end else if (state == RUN) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          Res_data  <= Result;
          Res_index <= pc;
          if (is_last) begin
            In <= NOP;
          end else begin
            pc  <= pc + 1'b1;
            In  <= rd_data;
            cnt <= CNT_RELOAD;
          end
        end
      end
    end
  end

endmodule
